// File: rtl/usb_rx_pkg.sv
// Shared types and constants for the USB full-speed receive line decoder.
package usb_rx_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SYNC,
    RECEIVE,
    EOP_WAIT,
    ERROR
  } rx_state_e;

  // Encoded as {d_plus, d_minus}; the invalid (1,1) level folds into SE0.
  typedef enum logic [1:0] {
    LINE_SE0 = 2'b00,
    LINE_K   = 2'b01,
    LINE_J   = 2'b10
  } line_e;

  // Decoded SYNC bits, LSB received first: seven 0s then a 1 (KJKJKJKK).
  localparam logic [7:0] SYNC_PATTERN    = 8'b1000_0000;
  localparam int         DEF_SYNC_LEN    = 8;
  localparam int         DEF_STUFF_LIMIT = 6;

  function automatic line_e decode_line(input logic dp, input logic dm);
    case ({dp, dm})
      2'b10:   return LINE_J;
      2'b01:   return LINE_K;
      default: return LINE_SE0;
    endcase
  endfunction

endpackage

// File: rtl/usb_rx_if.sv
// Line-side and decoded-bit signals of the USB receive decoder.
interface usb_rx_if;
  logic d_plus;
  logic d_minus;
  logic shift_en;
  logic receiving;
  logic data_bit;
  logic bit_valid;
  logic eop;
  logic rx_error;

  modport master (
    output d_plus, d_minus, shift_en,
    input  receiving, data_bit, bit_valid, eop, rx_error
  );

  modport slave (
    input  d_plus, d_minus, shift_en,
    output receiving, data_bit, bit_valid, eop, rx_error
  );
endinterface

// File: rtl/usb_line_sync.sv
// Two-flop synchronizer for one raw USB line; reset value is the idle level.
module usb_line_sync #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge value of its source.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= RESET_VAL;
      q    <= RESET_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/usb_rx_decoder.sv
// USB full-speed receive decoder: start detect, SYNC, NRZI decode, unstuffing, EOP.
// Define USB_RX_SYNC_CHECK_EN to compare the SYNC field; otherwise it is only consumed.
module usb_rx_decoder
  import usb_rx_pkg::*;
#(
  parameter int SYNC_LEN    = DEF_SYNC_LEN,
  parameter int STUFF_LIMIT = DEF_STUFF_LIMIT
) (
  input  logic     clk,
  input  logic     rst,
  usb_rx_if.slave  rx
);

  localparam int             SC_W      = (SYNC_LEN > 1) ? $clog2(SYNC_LEN) : 1;
  localparam logic [SC_W-1:0] SYNC_LAST = SC_W'(SYNC_LEN - 1);
  localparam logic [2:0]     STUFF_MAX = 3'(STUFF_LIMIT);

  logic dp_s, dm_s, dp_q;

  usb_line_sync #(.RESET_VAL(1'b1)) u_sync_dp (
    .clk (clk), .rst (rst), .d (rx.d_plus),  .q (dp_s)
  );
  usb_line_sync #(.RESET_VAL(1'b0)) u_sync_dm (
    .clk (clk), .rst (rst), .d (rx.d_minus), .q (dm_s)
  );

  rx_state_e       state, state_nxt;
  line_e           line, prev_line, prev_nxt;
  logic [2:0]      ones_cnt, ones_nxt;
  logic [SC_W-1:0] sync_cnt, sync_cnt_nxt;
  logic            se0_seen, se0_seen_nxt;
  logic            receiving_q, receiving_nxt;
  logic            data_bit_q, data_bit_nxt;
  logic            bit_valid_q, bit_valid_nxt;
  logic            eop_q, eop_nxt;
  logic            rx_error_q, rx_error_nxt;

  logic is_jk, dec_bit, dp_fall;

  assign line    = decode_line(dp_s, dm_s);
  assign is_jk   = (line == LINE_J) || (line == LINE_K);
  assign dec_bit = (line == prev_line);
  assign dp_fall = dp_q & ~dp_s;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    // NOTE: every variable gets a default first so no path infers a latch.
    state_nxt     = state;
    prev_nxt      = prev_line;
    ones_nxt      = ones_cnt;
    sync_cnt_nxt  = sync_cnt;
    se0_seen_nxt  = se0_seen;
    data_bit_nxt  = data_bit_q;
    bit_valid_nxt = 1'b0;
    eop_nxt       = 1'b0;
    rx_error_nxt  = rx_error_q;

    case (state)
      IDLE: begin
        prev_nxt = LINE_J;
        if (dp_fall) begin
          state_nxt    = SYNC;
          ones_nxt     = '0;
          sync_cnt_nxt = '0;
          rx_error_nxt = 1'b0;
        end
      end

      SYNC: begin
        if (rx.shift_en) begin
          if (is_jk) prev_nxt = line;
          sync_cnt_nxt = sync_cnt + 1'b1;
`ifdef USB_RX_SYNC_CHECK_EN
          if (!is_jk || (dec_bit != SYNC_PATTERN[sync_cnt])) state_nxt = ERROR;
          else if (sync_cnt == SYNC_LAST)                    state_nxt = RECEIVE;
`else
          if (sync_cnt == SYNC_LAST) state_nxt = RECEIVE;
`endif
        end
      end

      RECEIVE: begin
        if (rx.shift_en) begin
          if (!is_jk) begin
            state_nxt = EOP_WAIT;
          end else begin
            prev_nxt = line;
            // After STUFF_LIMIT ones the next bit must be the stuffed 0.
            if (ones_cnt == STUFF_MAX) begin
              if (dec_bit) state_nxt = ERROR;
              else         ones_nxt  = '0;
            end else begin
              bit_valid_nxt = 1'b1;
              data_bit_nxt  = dec_bit;
              ones_nxt      = dec_bit ? ones_cnt + 3'd1 : 3'd0;
            end
          end
        end
      end

      EOP_WAIT: begin
        if (rx.shift_en) begin
          case (line)
            LINE_J: begin
              eop_nxt   = 1'b1;
              state_nxt = IDLE;
            end
            LINE_K:  state_nxt = ERROR;
            default: ;
          endcase
        end
      end

      ERROR: begin
        if (rx.shift_en) begin
          if (!is_jk)                         se0_seen_nxt = 1'b1;
          else if (line == LINE_K)            se0_seen_nxt = 1'b0;
          else if (se0_seen)                  state_nxt    = IDLE;
        end
      end

      default: state_nxt = IDLE;
    endcase

    if ((state_nxt == ERROR) && (state != ERROR)) begin
      rx_error_nxt = 1'b1;
      se0_seen_nxt = 1'b0;
    end

    receiving_nxt = (state_nxt != IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dp_q        <= 1'b1;
      prev_line   <= LINE_J;
      ones_cnt    <= '0;
      sync_cnt    <= '0;
      se0_seen    <= 1'b0;
      receiving_q <= 1'b0;
      data_bit_q  <= 1'b1;
      bit_valid_q <= 1'b0;
      eop_q       <= 1'b0;
      rx_error_q  <= 1'b0;
    end else begin
      dp_q        <= dp_s;
      prev_line   <= prev_nxt;
      ones_cnt    <= ones_nxt;
      sync_cnt    <= sync_cnt_nxt;
      se0_seen    <= se0_seen_nxt;
      receiving_q <= receiving_nxt;
      data_bit_q  <= data_bit_nxt;
      bit_valid_q <= bit_valid_nxt;
      eop_q       <= eop_nxt;
      rx_error_q  <= rx_error_nxt;
    end
  end

  assign rx.receiving = receiving_q;
  assign rx.data_bit  = data_bit_q;
  assign rx.bit_valid = bit_valid_q;
  assign rx.eop       = eop_q;
  assign rx.rx_error  = rx_error_q;

endmodule

// File: tb/tb_usb_rx_decoder.sv
// Self-checking bench for usb_rx_decoder: NRZI/stuffing encoder drives packets,
// a scoreboard queue holds expected payload bits. Honors USB_RX_SYNC_CHECK_EN.
module tb_usb_rx_decoder;
  import usb_rx_pkg::*;

  localparam logic [1:0] LJ   = 2'b10;
  localparam logic [1:0] LK   = 2'b01;
  localparam logic [1:0] LSE0 = 2'b00;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  usb_rx_if rx();

  usb_rx_decoder dut (
    .clk (clk),
    .rst (rst),
    .rx  (rx.slave)
  );

  typedef struct {
    string       name;
    logic [15:0] payload;
    int          nbits;
    bit          stuff;
    int          exp_valid;
    int          exp_eop;
    bit          exp_err;
  } vec_t;

  vec_t vecs[6];

  int   checks   = 0;
  int   failures = 0;
  logic exp_q[$];
  logic exp_bit;
  int   eop_cnt  = 0;
  logic eop_prev = 1'b0;
  bit   chk_start = 1'b0;
  logic err_pre, err_post;
  logic [1:0] level;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h @%0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard side: pop one expected bit per bit_valid strobe.
  always @(negedge clk) begin
    if (!rst) begin
      if (rx.bit_valid) begin
        if (exp_q.size() == 0) begin
          check("unexpected_bit_valid", 32'd1, 32'd0);
        end else begin
          exp_bit = exp_q.pop_front();
          check("data_bit", {31'd0, rx.data_bit}, {31'd0, exp_bit});
        end
      end
      if (rx.eop) begin
        eop_cnt++;
        check("eop_width", {31'd0, eop_prev}, 32'd0);
      end
      eop_prev = rx.eop;
    end
  end

  // One USB bit time: 8 clocks with the timer strobe in cycle 3.
  task automatic send_bit(input logic [1:0] lv);
    {rx.d_plus, rx.d_minus} = lv;
    for (int c = 0; c < 8; c++) begin
      rx.shift_en = (c == 3);
      @(posedge clk);
      @(negedge clk);
      if (chk_start && c == 1) check("start_not_early", {31'd0, rx.receiving}, 32'd0);
      if (chk_start && c == 2) begin
        check("start_latency", {31'd0, rx.receiving}, 32'd1);
        check("err_cleared_at_start", {31'd0, rx.rx_error}, 32'd0);
      end
      if (c == 2) err_pre  = rx.rx_error;
      if (c == 3) err_post = rx.rx_error;
    end
    rx.shift_en = 1'b0;
    chk_start   = 1'b0;
  endtask

  task automatic nrzi(input logic b);
    if (!b) level = (level == LJ) ? LK : LJ;
    send_bit(level);
  endtask

  task automatic send_sync();
    level     = LJ;
    chk_start = 1'b1;
    for (int i = 0; i < 7; i++) nrzi(1'b0);
    nrzi(1'b1);
  endtask

  task automatic send_payload(input logic [15:0] data, input int n, input bit stuff);
    int ones;
    ones = 0;
    for (int i = 0; i < n; i++) begin
      nrzi(data[i]);
      ones = data[i] ? ones + 1 : 0;
      if (stuff && ones == 6) begin
        nrzi(1'b0);
        ones = 0;
      end
    end
  endtask

  task automatic send_eop();
    send_bit(LSE0);
    send_bit(LSE0);
    send_bit(LJ);
    level = LJ;
  endtask

  task automatic push_bits(input logic [15:0] data, input int n);
    for (int i = 0; i < n; i++) exp_q.push_back(data[i]);
  endtask

  task automatic run_vec(input vec_t v);
    eop_cnt = 0;
    push_bits(v.payload, v.exp_valid);
    send_sync();
    send_payload(v.payload, v.nbits, v.stuff);
    send_eop();
    send_bit(LJ);
    check({v.name, "_bits_left"}, exp_q.size(), 32'd0);
    check({v.name, "_eop_count"}, eop_cnt, v.exp_eop);
    check({v.name, "_rx_error"}, {31'd0, rx.rx_error}, {31'd0, v.exp_err});
    check({v.name, "_receiving"}, {31'd0, rx.receiving}, 32'd0);
    exp_q.delete();
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_receiving"}, {31'd0, rx.receiving}, 32'd0);
    check({tag, "_data_bit"},  {31'd0, rx.data_bit},  32'd1);
    check({tag, "_bit_valid"}, {31'd0, rx.bit_valid}, 32'd0);
    check({tag, "_eop"},       {31'd0, rx.eop},       32'd0);
    check({tag, "_rx_error"},  {31'd0, rx.rx_error},  32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{"clean_a5",   16'h00A5,  8, 1'b1,  8, 1, 1'b0};
    vecs[1] = '{"stuff_ff",   16'h00FF,  8, 1'b1,  8, 1, 1'b0};
    vecs[2] = '{"zeros",      16'h0000,  8, 1'b1,  8, 1, 1'b0};
    vecs[3] = '{"stuff_ffff", 16'hFFFF, 16, 1'b1, 16, 1, 1'b0};
    vecs[4] = '{"stuff_err",  16'h007F,  8, 1'b0,  6, 0, 1'b1};
    vecs[5] = '{"stuff_3f",   16'h003F,  8, 1'b1,  8, 1, 1'b0};

    rst = 1'b1;
    {rx.d_plus, rx.d_minus} = LJ;
    rx.shift_en = 1'b0;
    level = LJ;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b0;
    @(negedge clk);
    send_bit(LJ);
    send_bit(LJ);

    for (int i = 0; i < 6; i++) run_vec(vecs[i]);

    // Stuff error timing: rx_error rises right after the 7th 1 is sampled.
    eop_cnt = 0;
    push_bits(16'h003F, 6);
    send_sync();
    for (int i = 0; i < 6; i++) nrzi(1'b1);
    check("stuff7_no_err_after_6", {31'd0, err_post}, 32'd0);
    nrzi(1'b1);
    check("stuff7_err_before_edge", {31'd0, err_pre}, 32'd0);
    check("stuff7_err_after_edge", {31'd0, err_post}, 32'd1);
    check("stuff7_still_receiving", {31'd0, rx.receiving}, 32'd1);
    send_eop();
    check("stuff7_eop_count", eop_cnt, 32'd0);
    check("stuff7_idle", {31'd0, rx.receiving}, 32'd0);
    check("stuff7_err_sticky", {31'd0, rx.rx_error}, 32'd1);
    check("stuff7_bits_left", exp_q.size(), 32'd0);
    exp_q.delete();

    // Bad SYNC KJKJKJKJ followed by payload 0xA5 and a normal EOP.
    eop_cnt   = 0;
    level     = LJ;
    chk_start = 1'b1;
`ifndef USB_RX_SYNC_CHECK_EN
    push_bits(16'h00A5, 8);
`endif
    for (int i = 0; i < 8; i++) begin
      level = (level == LJ) ? LK : LJ;
      send_bit(level);
      if (i == 6) check("badsync_no_err_before_8th", {31'd0, err_post}, 32'd0);
    end
`ifdef USB_RX_SYNC_CHECK_EN
    check("badsync_err_after_8th", {31'd0, err_post}, 32'd1);
    send_payload(16'h00A5, 8, 1'b1);
    send_eop();
    check("badsync_eop_count", eop_cnt, 32'd0);
    check("badsync_err_sticky", {31'd0, rx.rx_error}, 32'd1);
`else
    check("badsync_no_err", {31'd0, err_post}, 32'd0);
    send_payload(16'h00A5, 8, 1'b1);
    send_eop();
    check("badsync_eop_count", eop_cnt, 32'd1);
    check("badsync_err", {31'd0, rx.rx_error}, 32'd0);
`endif
    check("badsync_idle", {31'd0, rx.receiving}, 32'd0);
    check("badsync_bits_left", exp_q.size(), 32'd0);
    exp_q.delete();

    // SE0 then K instead of J: error, no eop, recovers after SE0,J.
    eop_cnt = 0;
    push_bits(16'h00A5, 8);
    send_sync();
    send_payload(16'h00A5, 8, 1'b1);
    send_bit(LSE0);
    send_bit(LK);
    check("eopk_err", {31'd0, err_post}, 32'd1);
    check("eopk_receiving", {31'd0, rx.receiving}, 32'd1);
    send_bit(LSE0);
    send_bit(LJ);
    level = LJ;
    check("eopk_eop_count", eop_cnt, 32'd0);
    check("eopk_idle", {31'd0, rx.receiving}, 32'd0);
    check("eopk_bits_left", exp_q.size(), 32'd0);
    exp_q.delete();

    // Reset mid-payload, then a fresh packet must decode cleanly.
    push_bits(16'h00A5, 4);
    send_sync();
    send_payload(16'h0005, 4, 1'b1);
    check("midrst_pre_data_bit", {31'd0, rx.data_bit}, 32'd0);
    check("midrst_pre_receiving", {31'd0, rx.receiving}, 32'd1);
    rst = 1'b1;
    #1;
    check_reset_outputs("midrst");
    exp_q.delete();
    {rx.d_plus, rx.d_minus} = LJ;
    rx.shift_en = 1'b0;
    level = LJ;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    send_bit(LJ);
    send_bit(LJ);
    run_vec(vecs[0]);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/usb_rx_decoder.md
# usb_rx_decoder

USB full-speed receive line decoder: synchronizes raw D+/D−, detects packet start, validates SYNC, NRZI-decodes, removes stuffed bits and detects EOP. Sits directly upstream of the rx bit-timer: it drives `receiving`, which starts that timer, and consumes the timer's single-cycle mid-bit `shift_en` strobe. Decoded payload bits go downstream to the byte shift register.

## Interface
- `SYNC_LEN`, default 8: number of decoded bits in the SYNC field.
- `STUFF_LIMIT`, default 6: consecutive decoded 1s after which the next bit is a stuffed bit.

Ports:
- `clk`  in  1  system clock; 8 clocks per USB bit time.
- `rst`  in  1  reset, asynchronous, active-high.
- `d_plus`  in  1  raw D+ line, asynchronous to `clk`.
- `d_minus`  in  1  raw D− line, asynchronous to `clk`.
- `shift_en`  in  1  one-cycle mid-bit sample strobe from the rx bit-timer.
- `receiving`  out  1  high from packet start until return to IDLE.
- `data_bit`  out  1  decoded, unstuffed bit.
- `bit_valid`  out  1  one-cycle strobe; `data_bit` is a payload bit.
- `eop`  out  1  one-cycle pulse on a valid end of packet.
- `rx_error`  out  1  sticky error flag; cleared on the next packet start.

## Operation
- Line states, from the synchronized lines: J = (1,0), K = (0,1), SE0 = (0,0), (1,1) = invalid (handled as SE0).
- `prev_line`: last sampled J/K level. Reset value J.
- Decoded bit = 1 if the current sample equals `prev_line`, else 0.
- States:
  - IDLE: `receiving`=0. A falling edge on synchronized D+ (J→K) goes to SYNC and sets `receiving`=1. `prev_line` is forced to J.
  - SYNC: count `SYNC_LEN` samples. The decoded sequence must be 0,0,0,0,0,0,0,1 (KJKJKJKK).
    - Mismatch → ERROR.
    - Match after the last bit → RECEIVE.
    - SYNC bits never assert `bit_valid`.
  - RECEIVE, on each `shift_en`:
    - SE0 → EOP_WAIT. SE0 takes priority over stuff checks.
    - Else, if `ones_cnt`==`STUFF_LIMIT`:
      - Decoded 0: drop the bit, `ones_cnt`←0, no `bit_valid`.
      - Decoded 1: stuff error → ERROR.
    - Else, emit the bit with `bit_valid`. `ones_cnt` increments on 1 and clears on 0.
  - EOP_WAIT, on the next `shift_en`:
    - J → pulse `eop`, go to IDLE.
    - SE0 → stay (a second SE0 bit is legal).
    - K → ERROR.
  - ERROR: `rx_error`=1, `receiving` stays 1 so sampling continues. Waits for SE0 followed by J, then goes to IDLE with no `eop` pulse.
- `rx_error` clears on the IDLE→SYNC transition.
- `ones_cnt` is a 3-bit counter, saturating at `STUFF_LIMIT`. Reset 0. Cleared on entry to SYNC.
- Edges on D+ outside IDLE are ignored.

## Timing
- Synchronizer latency: 2 cycles.
- Start detect: `receiving` rises on the first clock edge after synchronized D+ falls, i.e. 3 cycles after the raw J→K edge.
- Bit sampling: the timer asserts `shift_en` at its count 3, which places sampling near mid-bit.
- `data_bit`, `bit_valid`, `eop`, `rx_error` are all registered: they update on the clock edge after the qualifying `shift_en`.
- `bit_valid` and `eop` are exactly one cycle wide.
- `receiving` falls on the same edge on which `eop` pulses, or the edge on which ERROR exits.
- Reset values:
  - Outputs: `receiving`=0, `data_bit`=1, `bit_valid`=0, `eop`=0, `rx_error`=0.
  - Internal: state=IDLE, `prev_line`=J, `ones_cnt`=0, synchronizer flops=J (1,0).
- Reset mid-packet: all state returns to reset values immediately. The next packet requires a fresh J→K edge.

## Configuration
- `USB_RX_SYNC_CHECK_EN` defined: SYNC pattern is checked as above; a mismatch enters ERROR.
- Not defined: the `SYNC_LEN` bits are consumed without comparison and SYNC always proceeds to RECEIVE. Stuff and EOP checks are unchanged.

## Structure
- Package `usb_rx_pkg`:
  - state enum (IDLE, SYNC, RECEIVE, EOP_WAIT, ERROR);
  - line-state encoding (J, K, SE0);
  - `SYNC_PATTERN` = 8'b1000_0000 (LSB received first);
  - default `STUFF_LIMIT` and `SYNC_LEN`.
- Sub-module `usb_line_sync`: a 2-flop synchronizer with a parameterized reset value, instantiated once per line.

## Test plan
- Clean packet: SYNC, payload 0xA5, SE0 SE0 J → 8 `bit_valid` pulses with bits 1,0,1,0,0,1,0,1; one `eop` pulse; `rx_error`=0.
- Stuffing: payload 0xFF → 8 valid 1s; the stuffed 0 after six 1s produces no `bit_valid`; `rx_error`=0.
- Stuff error: seven consecutive decoded 1s → `rx_error`=1 one cycle after the 7th `shift_en`; no `eop`; returns to IDLE after SE0,J.
- Bad SYNC: KJKJKJKJ with the macro defined → `rx_error`=1 after the 8th sample. Without the macro → proceeds to RECEIVE.
- EOP followed by K instead of J → ERROR, `rx_error`=1, no `eop` pulse.
- Assert `rst` mid-payload → all outputs at reset values the same cycle; a new packet decodes correctly.
